// File: rtl/router_pkg.sv
// Shared types and constants for the router output-side scheduler.
// Also provides the round-robin pointer advance helper.
package router_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    BODY   = 2'd2
  } state_t;

  localparam int NUM_CH  = 3;
  localparam int LEN_MSB = 7;
  localparam int LEN_LSB = 2;
  localparam int ADDR_W  = 2;

  localparam logic [1:0] GRANT_NONE = 2'd3;

  // Remaining-byte counter must hold the largest length plus one (the parity byte).
  localparam int REM_W = LEN_MSB - LEN_LSB + 2;

  // Next channel after ch, wrapping 2 -> 0.
  function automatic logic [1:0] nextCh(input logic [1:0] ch);
    return (ch >= 2'd2) ? 2'd0 : ch + 2'd1;
  endfunction

endpackage

// File: rtl/router_rr_pick.sv
// Rotating priority encoder: returns the first requesting channel
// searching ptr, ptr+1, ptr+2 (mod 3).
module router_rr_pick
  import router_pkg::*;
(
  input  logic [NUM_CH-1:0] i_req,
  input  logic [1:0]        i_ptr,
  output logic              o_any,
  output logic [1:0]        o_idx
);

  // Search order is rotated so the channel at ptr has the highest priority.
  always_comb begin
    o_any = |i_req;
    o_idx = 2'd0;
    case (i_ptr)
      2'd1: begin
        if (i_req[1])      o_idx = 2'd1;
        else if (i_req[2]) o_idx = 2'd2;
        else if (i_req[0]) o_idx = 2'd0;
      end
      2'd2: begin
        if (i_req[2])      o_idx = 2'd2;
        else if (i_req[0]) o_idx = 2'd0;
        else if (i_req[1]) o_idx = 2'd1;
      end
      default: begin
        if (i_req[0])      o_idx = 2'd0;
        else if (i_req[1]) o_idx = 2'd1;
        else if (i_req[2]) o_idx = 2'd2;
      end
    endcase
  end

endmodule

// File: rtl/router_out_arbiter.sv
// Output-side scheduler for the 1x3 router. Grants one FIFO at a time,
// round-robin per packet, pops header/payload/parity to the downstream port,
// and soft-resets a channel whose downstream stalls for TIMEOUT cycles.
// Optional macro ROUTER_PARITY_CHECK_EN builds the running-XOR parity checker.
module router_out_arbiter
  import router_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        vld_out,
  input  logic [DATA_W-1:0] fifo_dout_0,
  input  logic [DATA_W-1:0] fifo_dout_1,
  input  logic [DATA_W-1:0] fifo_dout_2,
  input  logic              out_ready,
  output logic [2:0]        read_enb,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [1:0]        grant,
  output logic              pkt_done,
  output logic [2:0]        soft_reset,
  output logic              busy,
  output logic              parity_err
);

  state_t            r_state;
  logic [1:0]        r_ptr;
  logic [1:0]        r_g;
  logic [REM_W-1:0]  r_rem;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_softReset;

  logic              w_pickAny;
  logic [1:0]        w_pickIdx;
  logic              w_gVld;
  logic [DATA_W-1:0] w_head;
  logic              w_active;
  logic              w_pop;
  logic              w_stall;
  logic              w_parityPop;
  logic              w_timeout;

  router_rr_pick uPick (
    .i_req (vld_out),
    .i_ptr (r_ptr),
    .o_any (w_pickAny),
    .o_idx (w_pickIdx)
  );

  // Select the granted FIFO's status and head word, then derive pop/stall strobes.
  always_comb begin
    w_gVld = 1'b0;
    w_head = '0;
    case (r_g)
      2'd0:    begin w_gVld = vld_out[0]; w_head = fifo_dout_0; end
      2'd1:    begin w_gVld = vld_out[1]; w_head = fifo_dout_1; end
      2'd2:    begin w_gVld = vld_out[2]; w_head = fifo_dout_2; end
      default: begin w_gVld = 1'b0;       w_head = '0;          end
    endcase
    w_active    = (r_state != IDLE);
    w_pop       = w_active && w_gVld && out_ready;
    w_stall     = w_active && w_gVld && !out_ready;
    w_parityPop = w_pop && (r_state == BODY) && (r_rem == REM_W'(1));
    w_timeout   = w_stall && (r_cnt == CNT_W'(TIMEOUT - 1));
  end

  // Downstream-facing outputs; everything idles at zero except grant.
  always_comb begin
    read_enb   = w_pop ? (3'b001 << r_g) : 3'b000;
    dout       = w_pop ? w_head : '0;
    dout_valid = w_pop;
    grant      = w_active ? r_g : GRANT_NONE;
    pkt_done   = w_parityPop;
    busy       = w_active;
    soft_reset = r_softReset;
  end

  // Packet FSM with stall counter; a timeout abandons the packet and passes the turn on.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ptr       <= 2'd0;
      r_g         <= 2'd0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_softReset <= 3'b000;
    end else begin
      r_softReset <= 3'b000;
      case (r_state)
        IDLE: begin
          if (w_pickAny) begin
            r_g     <= w_pickIdx;
            r_cnt   <= '0;
            r_state <= HEADER;
          end
        end
        HEADER: begin
          if (w_pop) begin
            r_rem   <= REM_W'(w_head[LEN_MSB:LEN_LSB]) + REM_W'(1);
            r_cnt   <= '0;
            r_state <= BODY;
          end
        end
        BODY: begin
          if (w_pop) begin
            r_rem <= r_rem - REM_W'(1);
            r_cnt <= '0;
            if (r_rem == REM_W'(1)) begin
              r_ptr   <= nextCh(r_g);
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
      if (w_timeout) begin
        r_softReset <= 3'b001 << r_g;
        r_ptr       <= nextCh(r_g);
        r_state     <= IDLE;
      end else if (w_stall) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

`ifdef ROUTER_PARITY_CHECK_EN
  logic [DATA_W-1:0] r_xor;

  // Running XOR of header and payload, restarted whenever a new grant is issued.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_xor <= '0;
    end else if ((r_state == IDLE) && w_pickAny) begin
      r_xor <= '0;
    end else if (w_pop && !w_parityPop) begin
      r_xor <= r_xor ^ w_head;
    end
  end

  assign parity_err = w_parityPop && (r_xor != w_head);
`else
  assign parity_err = 1'b0;
`endif

endmodule
